// File: rtl/axis_frame_gen_if.sv
// AXI4-Stream interface bundle shared by stream producers and consumers.
// Field widths are fixed per instance; TWAKEUP_ENABLE selects whether twakeup is meaningful.
interface AXIS_IF #(
    parameter int TDATA_WIDTH    = 32,
    parameter int TKEEP_WIDTH    = TDATA_WIDTH / 8,
    parameter int TID_WIDTH      = 8,
    parameter int TDEST_WIDTH    = 4,
    parameter int TUSER_WIDTH    = 1,
    parameter bit TWAKEUP_ENABLE = 1'b0
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tstrb;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport Transmitter (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport Receiver (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        output tready
    );
endinterface

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame generator: bursts of fixed-length frames carrying an incrementing byte pattern,
// with an optional idle gap between frames and a level stop request honoured at frame boundaries.
module axis_frame_gen (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] frame_len,
    input  logic [15:0] frame_count,
    input  logic [7:0]  gap_cycles,
    output logic        busy,
    output logic        done,
    output logic [31:0] frames_sent,
    AXIS_IF.Transmitter out_axis_if
);

    localparam int W = out_axis_if.TDATA_WIDTH;
    localparam int B = W / 8;

    if (W <= 0 || (W % 8) != 0 || out_axis_if.TKEEP_WIDTH != B || out_axis_if.TWAKEUP_ENABLE != 0) begin : g_bad_if
        $error("axis_frame_gen: unsupported AXIS_IF parameters");
    end

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] len_q;
    logic [15:0] count_q;
    logic [7:0]  gap_q;
    logic [7:0]  gap_cnt;
    logic [15:0] beat_idx;
    logic [15:0] bytes_left;

    logic        accept;
    logic        xfer;
    logic        is_last;
    logic        burst_done;
    logic [7:0]  base;
    logic [W-1:0] data_c;
    logic [B-1:0] keep_c;

    assign accept     = (state == IDLE) && start && (frame_len != 16'd0);
    assign xfer       = (state == SEND) && out_axis_if.tready;
    assign is_last    = 32'(bytes_left) <= 32'(B);
    assign burst_done = (count_q != 16'd0) && ((frames_sent + 32'd1) == {16'd0, count_q});
    assign base       = 8'(beat_idx * B);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = SEND;
            end
            SEND: begin
                if (xfer && is_last) begin
                    if (burst_done || stop)   state_nxt = IDLE;
                    else if (gap_q == 8'd0)   state_nxt = SEND;
                    else                      state_nxt = GAP;
                end
            end
            GAP: begin
                if (stop)                     state_nxt = IDLE;
                else if (gap_cnt == 8'd1)     state_nxt = SEND;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q       <= '0;
            count_q     <= '0;
            gap_q       <= '0;
            gap_cnt     <= '0;
            beat_idx    <= '0;
            bytes_left  <= '0;
            frames_sent <= '0;
            done        <= 1'b0;
        end else begin
            done <= (state != IDLE) && (state_nxt == IDLE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        len_q       <= frame_len;
                        count_q     <= frame_count;
                        gap_q       <= gap_cycles;
                        beat_idx    <= '0;
                        bytes_left  <= frame_len;
                        frames_sent <= '0;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (is_last) begin
                            frames_sent <= frames_sent + 32'd1;
                            beat_idx    <= '0;
                            bytes_left  <= len_q;
                            gap_cnt     <= gap_q;
                        end else begin
                            beat_idx    <= beat_idx + 16'd1;
                            bytes_left  <= bytes_left - 16'(B);
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // Lanes below the remaining byte count are kept; this yields all-ones on non-last beats.
    always_comb begin
        data_c = '0;
        keep_c = '0;
        if (state == SEND) begin
            for (int unsigned j = 0; j < B; j++) begin
                keep_c[j] = 32'(j) < 32'(bytes_left);
                if (keep_c[j]) data_c[j*8 +: 8] = base + 8'(j);
            end
        end
    end

    always_comb begin
        out_axis_if.tvalid  = (state == SEND);
        out_axis_if.tdata   = data_c;
        out_axis_if.tkeep   = keep_c;
        out_axis_if.tstrb   = keep_c;
        out_axis_if.tlast   = (state == SEND) && is_last;
        out_axis_if.tid     = '0;
        out_axis_if.tdest   = '0;
        out_axis_if.tuser   = '0;
        out_axis_if.twakeup = 1'b0;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_axis_frame_gen.sv
// Directed testbench for axis_frame_gen at W=32: beat contents, framing, gaps, stop, stalls and reset.
module tb_axis_frame_gen;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        stop;
    logic [15:0] frame_len;
    logic [15:0] frame_count;
    logic [7:0]  gap_cycles;
    logic        busy;
    logic        done;
    logic [31:0] frames_sent;

    AXIS_IF #(.TDATA_WIDTH(32)) axis ();

    axis_frame_gen dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .frame_len   (frame_len),
        .frame_count (frame_count),
        .gap_cycles  (gap_cycles),
        .busy        (busy),
        .done        (done),
        .frames_sent (frames_sent),
        .out_axis_if (axis.Transmitter)
    );

    typedef struct {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          c;
    } beat_t;

    beat_t       q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    int          stall_err = 0;
    int          stalls = 0;
    logic        held = 1'b0;
    logic [36:0] held_v = '0;
    logic        rnd = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observation happens mid-cycle; inputs change just after the rising edge.
    always @(negedge clk) begin
        if (axis.tvalid && axis.tready)
            q.push_back('{axis.tdata, axis.tkeep, axis.tlast, cyc});
        if (held && !(axis.tvalid && {axis.tdata, axis.tkeep, axis.tlast} == held_v))
            stall_err <= stall_err + 1;
        if (axis.tvalid && !axis.tready) stalls <= stalls + 1;
        held   <= reset_n && axis.tvalid && !axis.tready;
        held_v <= {axis.tdata, axis.tkeep, axis.tlast};
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (start && !busy && frame_len != 16'd0) start_cyc <= cyc;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [15:0] len, input logic [15:0] cnt, input logic [7:0] gap);
        start       = 1'b1;
        frame_len   = len;
        frame_count = cnt;
        gap_cycles  = gap;
        tick();
        start       = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int base;
        base = done_cnt;
        for (int i = 0; i < budget && done_cnt == base; i++) begin
            tick();
            if (rnd) axis.tready = 1'($urandom_range(0, 1));
        end
        axis.tready = 1'b1;
        check({tag, "_done_seen"}, 32'(done_cnt - base), 32'd1);
    endtask

    task automatic wait_frames(input string tag, input logic [31:0] n, input int budget);
        for (int i = 0; i < budget && frames_sent != n; i++) tick();
        check({tag, "_frames_reached"}, frames_sent, n);
    endtask

    task automatic chk_beat(input string tag, input int i, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
        if (i >= q.size()) begin
            check({tag, "_beat_missing"}, 32'(q.size()), 32'(i + 1));
        end else begin
            check({tag, "_data"}, q[i].d, d);
            check({tag, "_keep"}, 32'(q[i].k), 32'(k));
            check({tag, "_last"}, 32'(q[i].l), 32'(l));
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        frame_len   = '0;
        frame_count = '0;
        gap_cycles  = '0;
        axis.tready = 1'b1;
        tick();
        tick();

        check("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check("rst_tlast", 32'(axis.tlast), 32'd0);
        check("rst_tkeep", 32'(axis.tkeep), 32'd0);
        check("rst_tdata", axis.tdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frames", frames_sent, 32'd0);
        reset_n = 1'b1;
        tick();

        // 10-byte single frame
        q.delete();
        start_frame(16'd10, 16'd1, 8'd0);
        wait_done("f10", 50);
        check("f10_nbeats", 32'(q.size()), 32'd3);
        chk_beat("f10_b0", 0, 32'h03020100, 4'hF, 1'b0);
        chk_beat("f10_b1", 1, 32'h07060504, 4'hF, 1'b0);
        chk_beat("f10_b2", 2, 32'h00000908, 4'h3, 1'b1);
        if (q.size() == 3) begin
            check("f10_latency", 32'(q[0].c), 32'(start_cyc + 1));
            check("f10_done_lat", 32'(done_cyc), 32'(q[2].c + 1));
        end
        check("f10_frames", frames_sent, 32'd1);
        check("f10_busy", 32'(busy), 32'd0);

        // three 8-byte frames separated by 2 idle cycles
        q.delete();
        start_frame(16'd8, 16'd3, 8'd2);
        wait_done("gap", 100);
        repeat (4) tick();
        check("gap_nbeats", 32'(q.size()), 32'd6);
        chk_beat("gap_f1b1", 1, 32'h07060504, 4'hF, 1'b1);
        chk_beat("gap_f2b0", 2, 32'h03020100, 4'hF, 1'b0);
        chk_beat("gap_f3b1", 5, 32'h07060504, 4'hF, 1'b1);
        if (q.size() == 6) begin
            check("gap_b2b_in_frame", 32'(q[1].c - q[0].c), 32'd1);
            check("gap_between_1_2", 32'(q[2].c - q[1].c), 32'd3);
            check("gap_between_2_3", 32'(q[4].c - q[3].c), 32'd3);
        end
        check("gap_frames", frames_sent, 32'd3);
        check("gap_done_count", 32'(done_cnt), 32'd2);

        // 13 bytes under random backpressure
        q.delete();
        axis.tready = 1'b0;
        start_frame(16'd13, 16'd1, 8'd0);
        tick();
        rnd = 1'b1;
        wait_done("stall", 200);
        rnd = 1'b0;
        check("stall_nbeats", 32'(q.size()), 32'd4);
        chk_beat("stall_b2", 2, 32'h0B0A0908, 4'hF, 1'b0);
        chk_beat("stall_b3", 3, 32'h0000000C, 4'h1, 1'b1);
        check("stall_seen", 32'(stalls > 0), 32'd1);
        check("stall_stable", 32'(stall_err), 32'd0);

        // continuous burst, stop raised inside frame 5
        q.delete();
        start_frame(16'd8, 16'd0, 8'd0);
        wait_frames("cont", 32'd4, 100);
        tick();
        stop = 1'b1;
        wait_done("cont", 50);
        stop = 1'b0;
        check("cont_nbeats", 32'(q.size()), 32'd10);
        chk_beat("cont_f5b0", 8, 32'h03020100, 4'hF, 1'b0);
        chk_beat("cont_f5b1", 9, 32'h07060504, 4'hF, 1'b1);
        check("cont_frames", frames_sent, 32'd5);

        // stop while in the inter-frame gap
        q.delete();
        start_frame(16'd4, 16'd0, 8'd5);
        wait_frames("gstop", 32'd1, 50);
        stop = 1'b1;
        wait_done("gstop", 20);
        stop = 1'b0;
        check("gstop_nbeats", 32'(q.size()), 32'd1);
        if (q.size() == 1) check("gstop_done_lat", 32'(done_cyc), 32'(q[0].c + 2));
        check("gstop_frames", frames_sent, 32'd1);

        // start with zero length is ignored
        q.delete();
        begin
            int dc;
            dc = done_cnt;
            start_frame(16'd0, 16'd1, 8'd0);
            check("zlen_busy", 32'(busy), 32'd0);
            repeat (5) tick();
            check("zlen_nbeats", 32'(q.size()), 32'd0);
            check("zlen_no_done", 32'(done_cnt - dc), 32'd0);
        end

        // start while busy is ignored
        q.delete();
        start_frame(16'd16, 16'd1, 8'd0);
        tick();
        start     = 1'b1;
        frame_len = 16'd4;
        tick();
        start     = 1'b0;
        frame_len = 16'd16;
        check("rebusy_busy", 32'(busy), 32'd1);
        wait_done("rebusy", 50);
        check("rebusy_nbeats", 32'(q.size()), 32'd4);
        chk_beat("rebusy_b3", 3, 32'h0F0E0D0C, 4'hF, 1'b1);
        check("rebusy_frames", frames_sent, 32'd1);

        // asynchronous reset during beat 2
        q.delete();
        start_frame(16'd16, 16'd0, 8'd0);
        tick();
        reset_n = 1'b0;
        #1;
        check("arst_tvalid", 32'(axis.tvalid), 32'd0);
        check("arst_tdata", axis.tdata, 32'd0);
        check("arst_tkeep", 32'(axis.tkeep), 32'd0);
        check("arst_tlast", 32'(axis.tlast), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_frames", frames_sent, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        q.delete();
        repeat (10) tick();
        check("arst_idle_after", 32'(q.size()), 32'd0);
        check("arst_busy_after", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_gen.md
AXIS_FRAME_GEN -- requirements
Module: axis_frame_gen

Interface
REQ-001 SHALL have no module parameters; beat width W = out_axis_if.TDATA_WIDTH and byte lanes B = W/8, both taken from the interface.
REQ-002 SHALL assert at elaboration that W > 0, W % 8 == 0, out_axis_if.TKEEP_WIDTH == B and TWAKEUP_ENABLE == 0, failing with $error otherwise.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a frame burst; honoured only in IDLE.
REQ-006 stop  input  1  level request to end the burst after the current frame.
REQ-007 frame_len  input  16  bytes per frame, sampled on an accepted start.
REQ-008 frame_count  input  16  frames per burst, sampled on an accepted start; 0 = continuous until stop.
REQ-009 gap_cycles  input  8  idle cycles between frames, sampled on an accepted start.
REQ-010 busy  output  1  high in any state other than IDLE.
REQ-011 done  output  1  one-cycle pulse on return to IDLE.
REQ-012 frames_sent  output  32  count of completed frames since the last accepted start.
REQ-013 out_axis_if  AXIS_IF.Transmitter  generated stream.

Function
REQ-014 SHALL implement the states IDLE, SEND, GAP.
REQ-015 IDLE: start=1 with frame_len != 0 -> capture the inputs, clear frames_sent, go to SEND; start with frame_len == 0 is ignored.
REQ-016 SHALL assert tvalid in the first cycle of SEND, giving 1 cycle of latency from start.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 Beats per frame SHALL be ceil(frame_len/B).
REQ-019 Byte lane j of beat n SHALL carry (n*B + j) mod 256, restarting at 0 on every frame.
REQ-020 Non-last beats SHALL drive tkeep all ones.
REQ-021 The last beat SHALL drive tkeep as the low (frame_len mod B) bits set, or all ones when the remainder is 0.
REQ-022 Bytes in unkept lanes SHALL be 0.
REQ-023 tlast SHALL be 1 only on the last beat of a frame.
REQ-024 tstrb SHALL equal tkeep; tid, tdest, tuser and twakeup SHALL be 0.
REQ-025 AXIS handshake: a beat transfers when tvalid && tready; tvalid never drops and tdata/tkeep/tlast never change until that transfer.
REQ-026 On transfer of a beat with tlast=1, frames_sent SHALL increment by 1, wrapping at 2^32.
REQ-027 After that last-beat transfer: if the burst is complete (frames_sent+1 == frame_count with frame_count != 0) or stop=1 -> IDLE and pulse done.
REQ-028 Otherwise, when gap_cycles == 0, SHALL go directly to SEND with the next beat valid the following cycle (back-to-back).
REQ-029 Otherwise, when gap_cycles != 0, SHALL go to GAP with tvalid=0 for exactly gap_cycles cycles, then SEND.
REQ-030 stop asserted in GAP SHALL go to IDLE next cycle and pulse done.
REQ-031 stop SHALL never truncate a frame.
REQ-032 Beat counter SHALL be 16 bits, with no overflow for frame_len up to 65535 at B = 1.

Reset
REQ-033 reset_n low SHALL immediately (asynchronously) force IDLE, with tvalid, tlast, tkeep, tdata, busy, done and frames_sent all 0.
REQ-034 Reset mid-frame SHALL abandon the frame; after reset release nothing is sent until a new start.

Verification
REQ-035 W=32, frame_len=10, frame_count=1, gap=0, tready=1 -> 3 beats: 0x03020100, 0x07060504, 0x00000908 with tkeep 0xF, 0xF, 0x3 and tlast on beat 3; done 1 cycle later; frames_sent=1.
REQ-036 frame_len=8, frame_count=3, gap=2 -> frames of 2 beats each, exactly 2 tvalid-low cycles between frames, frames_sent=3, single done pulse.
REQ-037 Random tready (50%) with frame_len=13 -> beat contents held stable during stalls; 4 beats; last tkeep=0x1, last data 0x0000000C.
REQ-038 frame_count=0, stop raised mid-way through frame 5 -> frame 5 completes, then IDLE; frames_sent=5.
REQ-039 start while busy, and start with frame_len=0 in IDLE -> both ignored; no extra frames, busy unchanged.
REQ-040 reset_n low during beat 2 of a frame -> tvalid=0 in the same cycle; all outputs 0; stream idle after release until the next start.
